// File: rtl/alu_op_sequencer.sv
// Issues one instruction every 3 cycles to a combinational ALU: operands registered at accept,
// result captured one cycle later, written back the cycle after. instr_ready drops while busy or on a host write.
module alu_op_sequencer #(
  parameter int DATA_W = 4,
  parameter int NREG   = 4,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [AW-1:0]     instr_rd,
  input  logic [AW-1:0]     instr_rs1,
  input  logic [AW-1:0]     instr_rs2,
  input  logic              instr_imm_en,
  input  logic [DATA_W-1:0] instr_imm,
  input  logic              host_we,
  input  logic [AW-1:0]     host_waddr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [AW-1:0]     dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_s,
  input  logic [DATA_W-1:0] alu_y,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [AW-1:0]     res_rd,
  output logic              res_zero,
  output logic              busy,
  output logic [7:0]        instr_count
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   regs_d [NREG];
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [2:0]          alu_s_q, alu_s_d;
  logic [AW-1:0]       rd_q, rd_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic [AW-1:0]       res_rd_q, res_rd_d;
  logic                res_zero_q, res_zero_d;
  logic                res_valid_q, res_valid_d;
  logic [7:0]          count_q, count_d;

  // Host preload wins over a pending instruction, so ready is withheld during it.
  assign instr_ready = (state_q == IDLE) && !host_we && !rst;

  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_s_d     = alu_s_q;
    rd_d        = rd_q;
    res_data_d  = res_data_q;
    res_rd_d    = res_rd_q;
    res_zero_d  = res_zero_q;
    res_valid_d = res_valid_q;
    count_d     = count_q;
    case (state_q)
      IDLE: begin
        if (host_we) begin
          regs_d[host_waddr] = host_wdata;
        end else if (instr_valid) begin
          alu_a_d = regs_q[instr_rs1];
          alu_b_d = instr_imm_en ? instr_imm : regs_q[instr_rs2];
          alu_s_d = instr_op;
          rd_d    = instr_rd;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_data_d  = alu_y;
        res_zero_d  = (alu_y == '0);
        res_rd_d    = rd_q;
        res_valid_d = 1'b1;
        state_d     = WB;
      end
      WB: begin
        regs_d[res_rd_q] = res_data_q;
        res_valid_d      = 1'b0;
        count_d          = count_q + 8'd1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= '0;
      rd_q        <= '0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
      res_zero_q  <= 1'b0;
      res_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_s_q     <= alu_s_d;
      rd_q        <= rd_d;
      res_data_q  <= res_data_d;
      res_rd_q    <= res_rd_d;
      res_zero_q  <= res_zero_d;
      res_valid_q <= res_valid_d;
      count_q     <= count_d;
    end
  end

  assign dbg_rdata   = regs_q[dbg_raddr];
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_s       = alu_s_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_rd      = res_rd_q;
  assign res_zero    = res_zero_q;
  assign busy        = (state_q != IDLE);
  assign instr_count = count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboarded bench for alu_op_sequencer with a behavioural 4-bit ALU attached.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [1:0] instr_rd, instr_rs1, instr_rs2;
  logic       instr_imm_en;
  logic [3:0] instr_imm;
  logic       host_we;
  logic [1:0] host_waddr;
  logic [3:0] host_wdata;
  logic [1:0] dbg_raddr;
  logic [3:0] dbg_rdata;
  logic [3:0] alu_a, alu_b, alu_y;
  logic [2:0] alu_s;
  logic       res_valid;
  logic [3:0] res_data;
  logic [1:0] res_rd;
  logic       res_zero;
  logic       busy;
  logic [7:0] instr_count;

  alu_op_sequencer #(.DATA_W(4), .NREG(4)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
    .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
    .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd), .res_zero(res_zero),
    .busy(busy), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
    case (s)
      3'b000:  return a + b;
      3'b001:  return a - b;
      default: return a ^ b;
    endcase
  endfunction
  assign alu_y = alu_f(alu_a, alu_b, alu_s);

  typedef struct packed {
    logic [3:0] data;
    logic [1:0] rd;
    int         acc_cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         last_acc = 0;
  int         m_count = 0;
  logic [3:0] m_regs [4];
  logic       prev_rv = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every result strobe and retires it into the model.
  always @(negedge clk) begin
    if (res_valid) begin
      exp_t e;
      chk("res_pulse_width", {31'b0, prev_rv}, 32'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_res_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("res_data", {28'b0, res_data}, {28'b0, e.data});
        chk("res_rd", {30'b0, res_rd}, {30'b0, e.rd});
        chk("res_zero", {31'b0, res_zero}, {31'b0, (e.data == 4'd0)});
        chk("res_latency", cyc, e.acc_cyc + 1);
        m_regs[e.rd] = e.data;
        m_count++;
      end
    end
    prev_rv = res_valid;
  end

  task automatic host_write(input logic [1:0] a, input logic [3:0] d);
    host_we = 1'b1; host_waddr = a; host_wdata = d;
    @(posedge clk); #1;
    host_we = 1'b0;
    m_regs[a] = d;
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic ie, input logic [3:0] imm,
                       input bit keep, input bit expect_res);
    int waited = 0;
    logic [3:0] a, b;
    exp_t e;
    instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    instr_imm_en = ie; instr_imm = imm; instr_valid = 1'b1;
    @(negedge clk);
    while (!instr_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!instr_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    a = m_regs[rs1];
    b = ie ? imm : m_regs[rs2];
    last_acc = cyc;
    if (expect_res) begin
      e.data = alu_f(a, b, op); e.rd = rd; e.acc_cyc = cyc;
      sb_q.push_back(e);
    end
    chk("alu_a", {28'b0, alu_a}, {28'b0, a});
    chk("alu_b", {28'b0, alu_b}, {28'b0, b});
    chk("alu_s", {29'b0, alu_s}, {29'b0, op});
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
    if (!keep) instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < 4; i++) begin
      dbg_raddr = 2'(i);
      #1;
      chk(name, {28'b0, dbg_rdata}, {28'b0, m_regs[i]});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0;
    instr_imm_en = 1'b0; instr_imm = '0; host_we = 1'b0; host_waddr = '0; host_wdata = '0;
    dbg_raddr = '0;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_alu_a", {28'b0, alu_a}, 32'd0);
    chk("rst_alu_b", {28'b0, alu_b}, 32'd0);
    chk("rst_alu_s", {29'b0, alu_s}, 32'd0);
    chk("rst_res_data", {28'b0, res_data}, 32'd0);
    chk("rst_res_rd", {30'b0, res_rd}, 32'd0);
    chk("rst_res_zero", {31'b0, res_zero}, 32'd0);
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_count", {24'b0, instr_count}, 32'd0);
    chk("rst_ready", {31'b0, instr_ready}, 32'd1);
    check_regs("rst_dbg");

    // Basic add: r1=3, r2=5, r0 = 8
    @(posedge clk); #1;
    host_write(2'd1, 4'd3);
    host_write(2'd2, 4'd5);
    issue(3'b000, 2'd0, 2'd1, 2'd2, 1'b0, 4'd0, 1'b0, 1'b1);
    chk("add_alu_a_lit", {28'b0, alu_a}, 32'd3);
    chk("add_alu_b_lit", {28'b0, alu_b}, 32'd5);
    wait_idle();
    dbg_raddr = 2'd0; #1;
    chk("add_r0_lit", {28'b0, dbg_rdata}, 32'd8);
    chk("add_count_lit", {24'b0, instr_count}, 32'd1);

    // Immediate wrap 9+7=0 into r1, then back-to-back read of r1 with valid held high
    @(posedge clk); #1;
    host_write(2'd1, 4'd9);
    issue(3'b000, 2'd1, 2'd1, 2'd0, 1'b1, 4'd7, 1'b1, 1'b1);
    prev = last_acc;
    issue(3'b000, 2'd2, 2'd1, 2'd0, 1'b1, 4'd4, 1'b0, 1'b1);
    chk("b2b_spacing", last_acc - prev, 32'd3);
    wait_idle();
    dbg_raddr = 2'd1; #1;
    chk("wrap_r1_lit", {28'b0, dbg_rdata}, 32'd0);
    dbg_raddr = 2'd2; #1;
    chk("b2b_r2_lit", {28'b0, dbg_rdata}, 32'd4);

    // Host write collides with a presented instruction: write first, then r3 = r2 - r0 = 3
    @(posedge clk); #1;
    instr_op = 3'b001; instr_rd = 2'd3; instr_rs1 = 2'd2; instr_rs2 = 2'd0;
    instr_imm_en = 1'b0; instr_valid = 1'b1;
    host_we = 1'b1; host_waddr = 2'd0; host_wdata = 4'd1;
    @(negedge clk);
    chk("collide_ready", {31'b0, instr_ready}, 32'd0);
    @(posedge clk); #1;
    host_we = 1'b0;
    m_regs[0] = 4'd1;
    issue(3'b001, 2'd3, 2'd2, 2'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    wait_idle();
    dbg_raddr = 2'd3; #1;
    chk("sub_r3_lit", {28'b0, dbg_rdata}, 32'd3);
    check_regs("collide_regs");

    // Host write during EXEC is ignored
    @(posedge clk); #1;
    issue(3'b000, 2'd0, 2'd3, 2'd1, 1'b0, 4'd0, 1'b0, 1'b1);
    host_we = 1'b1; host_waddr = 2'd2; host_wdata = 4'd15;
    @(posedge clk); #1;
    host_we = 1'b0;
    wait_idle();
    dbg_raddr = 2'd2; #1;
    chk("ignored_host_r2", {28'b0, dbg_rdata}, 32'd4);
    check_regs("exec_host_regs");

    // Reset during EXEC drops the instruction
    @(posedge clk); #1;
    issue(3'b000, 2'd3, 2'd2, 2'd2, 1'b0, 4'd0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready_low", {31'b0, instr_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_count = 0;
    repeat (4) @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_count", {24'b0, instr_count}, 32'd0);
    chk("abort_res_data", {28'b0, res_data}, 32'd0);
    check_regs("abort_regs");

    // 256 completions wrap the counter back to zero
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      issue({2'b00, iv[0]}, iv[1:0], 2'(iv + 8'd1), 2'(iv + 8'd2), (i % 3 == 0), iv[3:0],
            (i != 255), 1'b1);
    end
    wait_idle();
    chk("count_wrap_lit", {24'b0, instr_count}, 32'd0);
    chk("count_wrap_model", {24'b0, instr_count}, {24'b0, 8'(m_count)});
    check_regs("loop_regs");
    chk("scoreboard_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
